mbs_bus_responder: RTL and testbench

Memory-side responder for the MBS core's multi-cycle controller. It accepts the controller's instruction-fetch strobe (`inst_re`) and data load/store strobes (`mem_re`/`mem_we`) and serves them from on-chip word SRAM with a configurable number of wait states. While an access is outstanding it drives `pause`, which holds the controller in its current state. It sits between the controller/datapath and the on-chip RAM, in place of a zero-latency memory model.

---
 rtl/mbs_bus_pkg.sv | 28 ++
 rtl/mbs_sram.sv | 22 ++
 rtl/mbs_bus_responder.sv | 122 ++++++++++++
 tb/tb_mbs_bus_responder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mbs_bus_pkg.sv
// Shared definitions for the MBS bus responder: FSM states, request kinds,
// default geometry and the address-legality helper.
package mbs_bus_pkg;

    localparam int unsigned ADDR_WIDTH_DEF  = 10;
    localparam int unsigned DATA_WIDTH_DEF  = 32;
    localparam int unsigned WAIT_CYCLES_DEF = 2;
    localparam int unsigned CNT_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        K_NONE  = 2'd0,
        K_FETCH = 2'd1,
        K_LOAD  = 2'd2,
        K_STORE = 2'd3
    } kind_e;

    // Byte address is bad when it is not word aligned or lies beyond the SRAM.
    function automatic logic addr_bad(input logic [31:0] a, input int unsigned aw);
        return (a[1:0] != 2'b00) || ((a >> (aw + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/mbs_sram.sv
// Single-port word SRAM with synchronous write and registered read.
module mbs_sram
    import mbs_bus_pkg::*;
#(
    parameter int unsigned AW = ADDR_WIDTH_DEF,
    parameter int unsigned DW = DATA_WIDTH_DEF
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/mbs_bus_responder.sv
// Memory-side responder: serves fetch/load/store strobes from on-chip SRAM
// after WAIT_CYCLES wait states, stalling the controller through pause_o.
module mbs_bus_responder
    import mbs_bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  inst_re_i,
    input  logic [31:0]           inst_addr_i,
    input  logic                  mem_re_i,
    input  logic                  mem_we_i,
    input  logic [31:0]           data_addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] inst_rdata_o,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  pause_o,
    output logic                  addr_err_o
);

    state_e                  state_q, state_d;
    kind_e                   kind_q, kind_d, req_kind;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d, ram_addr;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, ram_rdata;
    logic [DATA_WIDTH-1:0]   inst_rdata_q, data_rdata_q;
    logic                    err_q, err_d, addr_err_q;
    logic [31:0]             req_addr;
    logic                    req_any, ram_we;

    always_comb begin
        req_kind = K_NONE;
        req_addr = inst_addr_i;
        if (mem_we_i) begin
            req_kind = K_STORE;
            req_addr = data_addr_i;
        end else if (mem_re_i) begin
            req_kind = K_LOAD;
            req_addr = data_addr_i;
        end else if (inst_re_i) begin
            req_kind = K_FETCH;
        end
    end

    assign req_any = (req_kind != K_NONE);

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        cnt_d   = cnt_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    kind_d  = req_kind;
                    waddr_d = req_addr[ADDR_WIDTH+1:2];
                    wdata_d = wdata_i;
                    err_d   = addr_bad(req_addr, ADDR_WIDTH);
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign pause_o = !rst_i && ((state_q == ST_IDLE && req_any) || state_q == ST_WAIT);

    // The read is launched every cycle so the word is already at ram_rdata in DONE;
    // in IDLE it tracks the incoming request so zero-wait builds still line up.
    assign ram_addr = (state_q == ST_IDLE) ? req_addr[ADDR_WIDTH+1:2] : waddr_q;
    assign ram_we   = !rst_i && (state_q == ST_DONE) && (kind_q == K_STORE) && !err_q;

    mbs_sram #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_sram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            kind_q       <= K_NONE;
            cnt_q        <= '0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            addr_err_q   <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            cnt_q      <= cnt_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            addr_err_q <= (state_q == ST_DONE) && err_q;
            if (state_q == ST_DONE && kind_q == K_FETCH)
                inst_rdata_q <= err_q ? '0 : ram_rdata;
            if (state_q == ST_DONE && kind_q == K_LOAD)
                data_rdata_q <= err_q ? '0 : ram_rdata;
        end
    end

    assign inst_rdata_o = inst_rdata_q;
    assign data_rdata_o = data_rdata_q;
    assign addr_err_o   = addr_err_q;

endmodule

// File: tb/tb_mbs_bus_responder.sv
// Bench for mbs_bus_responder: a WAIT_CYCLES=2 instance checked against a
// word-array model, plus a WAIT_CYCLES=0 instance for the zero-wait timing.
module tb_mbs_bus_responder;

    localparam int AW  = 10;
    localparam int WA  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_inst_re = 0, a_mem_re = 0, a_mem_we = 0;
    logic [31:0] a_inst_addr = 0, a_data_addr = 0, a_wdata = 0;
    logic [31:0] a_inst_rdata, a_data_rdata;
    logic        a_pause, a_addr_err;

    logic        b_inst_re = 0, b_mem_re = 0, b_mem_we = 0;
    logic [31:0] b_inst_addr = 0, b_data_addr = 0, b_wdata = 0;
    logic [31:0] b_inst_rdata, b_data_rdata;
    logic        b_pause, b_addr_err;

    mbs_bus_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .WAIT_CYCLES(WA)) u_a (
        .clk_i(clk), .rst_i(rst), .inst_re_i(a_inst_re), .inst_addr_i(a_inst_addr),
        .mem_re_i(a_mem_re), .mem_we_i(a_mem_we), .data_addr_i(a_data_addr), .wdata_i(a_wdata),
        .inst_rdata_o(a_inst_rdata), .data_rdata_o(a_data_rdata), .pause_o(a_pause),
        .addr_err_o(a_addr_err));

    mbs_bus_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .WAIT_CYCLES(0)) u_b (
        .clk_i(clk), .rst_i(rst), .inst_re_i(b_inst_re), .inst_addr_i(b_inst_addr),
        .mem_re_i(b_mem_re), .mem_we_i(b_mem_we), .data_addr_i(b_data_addr), .wdata_i(b_wdata),
        .inst_rdata_o(b_inst_rdata), .data_rdata_o(b_data_rdata), .pause_o(b_pause),
        .addr_err_o(b_addr_err));

    int tests = 0;
    int fails = 0;

    // Reference model: word-indexed memory and the expected visible outputs.
    logic [31:0] ref_mem [int];
    logic [31:0] exp_ird = 0, exp_drd = 0;
    bit          exp_err = 0;

    task automatic model(input bit we, re, ie, input logic [31:0] da, ia, wd);
        logic [31:0] a;
        bit bad;
        int w;
        a   = (we || re) ? da : ia;
        bad = (a % 4 != 0) || (a >= (32'd4 << AW));
        w   = int'((a / 4) % (32'd1 << AW));
        exp_err = bad;
        if (we) begin
            if (!bad) ref_mem[w] = wd;
        end else if (re) exp_drd = bad ? 32'h0 : ref_mem[w];
        else if (ie)     exp_ird = bad ? 32'h0 : ref_mem[w];
    endtask

    // Runs one access on instance A; returns the number of cycles pause was high.
    // Ends one cycle after DONE, #1 past the negedge, where results are sampled.
    task automatic xact(input bit cont, we, re, ie, input logic [31:0] da, ia, wd,
                        input bit we2, re2, ie2, output int st);
        model(we, re, ie, da, ia, wd);
        if (!cont) begin
            @(negedge clk);
            a_mem_we = we; a_mem_re = re; a_inst_re = ie;
            a_data_addr = da; a_inst_addr = ia; a_wdata = wd;
        end
        #1;
        st = 0;
        while (a_pause === 1'b1 && st < 40) begin
            st++;
            @(negedge clk); #1;
        end
        a_mem_we = we2; a_mem_re = re2; a_inst_re = ie2;
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        int st;
        rst = 1; a_inst_re = 1; a_inst_addr = 0;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (a_pause !== 1'b0) begin fails++; $display("FAIL reset_pause got %b want 0", a_pause); end
        tests++; if (b_pause !== 1'b0) begin fails++; $display("FAIL reset_pause_b got %b want 0", b_pause); end
        tests++; if (a_inst_rdata !== 32'h0 || a_data_rdata !== 32'h0) begin
            fails++; $display("FAIL reset_rdata got %h/%h want 0/0", a_inst_rdata, a_data_rdata); end
        tests++; if (a_addr_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", a_addr_err); end
        a_inst_re = 0;
        @(negedge clk); rst = 0;
        exp_ird = 0; exp_drd = 0;
        st = 0;
    endtask

    task automatic test_fetch();
        int st;
        xact(0, 1, 0, 0, 32'h8, 0, 32'h2108000A, 0, 0, 0, st);
        xact(0, 0, 0, 1, 0, 32'h8, 0, 0, 0, 0, st);
        tests++; if (st !== WA + 1) begin fails++; $display("FAIL fetch_stall got %0d want %0d", st, WA + 1); end
        tests++; if (a_inst_rdata !== 32'h2108000A) begin
            fails++; $display("FAIL fetch_data got %h want 2108000a", a_inst_rdata); end
        tests++; if (a_addr_err !== 1'b0) begin fails++; $display("FAIL fetch_err got %b want 0", a_addr_err); end
        tests++; if (a_data_rdata !== exp_drd) begin
            fails++; $display("FAIL fetch_data_hold got %h want %h", a_data_rdata, exp_drd); end
    endtask

    task automatic test_back_to_back();
        int st1, st2;
        xact(0, 1, 0, 0, 32'h10, 0, 32'hDEADBEEF, 0, 1, 0, st1);
        xact(1, 0, 1, 0, 32'h10, 0, 0, 0, 0, 0, st2);
        tests++; if (st1 !== WA + 1 || st2 !== WA + 1) begin
            fails++; $display("FAIL b2b_stall got %0d,%0d want %0d", st1, st2, WA + 1); end
        tests++; if (a_data_rdata !== 32'hDEADBEEF) begin
            fails++; $display("FAIL b2b_load got %h want deadbeef", a_data_rdata); end
    endtask

    task automatic test_priority();
        int st;
        xact(0, 0, 1, 1, 32'h8, 32'h10, 0, 0, 0, 1, st);
        tests++; if (a_data_rdata !== 32'h2108000A) begin
            fails++; $display("FAIL prio_load got %h want 2108000a", a_data_rdata); end
        tests++; if (a_inst_rdata !== 32'h2108000A) begin
            fails++; $display("FAIL prio_inst_hold got %h want 2108000a", a_inst_rdata); end
        xact(1, 0, 0, 1, 32'h8, 32'h10, 0, 0, 0, 0, st);
        tests++; if (st !== WA + 1) begin fails++; $display("FAIL prio_fetch_stall got %0d want %0d", st, WA + 1); end
        tests++; if (a_inst_rdata !== 32'hDEADBEEF) begin
            fails++; $display("FAIL prio_fetch got %h want deadbeef", a_inst_rdata); end
    endtask

    task automatic test_errors();
        int st;
        xact(0, 1, 0, 0, 32'h0, 0, 32'h00000A0A, 0, 0, 0, st);
        xact(0, 1, 0, 0, 32'h13, 0, 32'h11111111, 0, 0, 0, st);
        tests++; if (a_addr_err !== 1'b1) begin fails++; $display("FAIL err_misalign got %b want 1", a_addr_err); end
        @(negedge clk); #1;
        tests++; if (a_addr_err !== 1'b0) begin fails++; $display("FAIL err_pulse got %b want 0", a_addr_err); end
        xact(0, 1, 0, 0, 32'h1000, 0, 32'h22222222, 0, 0, 0, st);
        tests++; if (a_addr_err !== 1'b1) begin fails++; $display("FAIL err_range got %b want 1", a_addr_err); end
        xact(0, 0, 1, 0, 32'h10, 0, 0, 0, 0, 0, st);
        tests++; if (a_data_rdata !== 32'hDEADBEEF) begin
            fails++; $display("FAIL err_word4 got %h want deadbeef", a_data_rdata); end
        xact(0, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, st);
        tests++; if (a_data_rdata !== 32'h00000A0A) begin
            fails++; $display("FAIL err_word0 got %h want 00000a0a", a_data_rdata); end
        xact(0, 0, 1, 0, 32'h3, 0, 0, 0, 0, 0, st);
        tests++; if (a_data_rdata !== 32'h0 || a_addr_err !== 1'b1) begin
            fails++; $display("FAIL err_load got %h/%b want 0/1", a_data_rdata, a_addr_err); end
    endtask

    task automatic test_wait0();
        @(negedge clk);
        b_mem_we = 1; b_data_addr = 0; b_wdata = 32'hCAFE0001;
        #1;
        tests++; if (b_pause !== 1'b1) begin fails++; $display("FAIL w0_store_pause got %b want 1", b_pause); end
        @(negedge clk); #1;
        tests++; if (b_pause !== 1'b0) begin fails++; $display("FAIL w0_store_done got %b want 0", b_pause); end
        b_mem_we = 0;
        @(negedge clk);
        b_inst_re = 1; b_inst_addr = 0;
        #1;
        tests++; if (b_pause !== 1'b1) begin fails++; $display("FAIL w0_fetch_pause got %b want 1", b_pause); end
        @(negedge clk); #1;
        tests++; if (b_pause !== 1'b0 || b_inst_rdata !== 32'h0) begin
            fails++; $display("FAIL w0_fetch_done got %b/%h want 0/0", b_pause, b_inst_rdata); end
        b_inst_re = 0;
        @(negedge clk); #1;
        tests++; if (b_inst_rdata !== 32'hCAFE0001) begin
            fails++; $display("FAIL w0_fetch_data got %h want cafe0001", b_inst_rdata); end
    endtask

    task automatic test_reset_mid();
        int st;
        xact(0, 1, 0, 0, 32'h20, 0, 32'h88888888, 0, 0, 0, st);
        @(negedge clk);
        a_mem_we = 1; a_data_addr = 32'h20; a_wdata = 32'h12345678;
        @(negedge clk);
        rst = 1;
        @(negedge clk); #1;
        tests++; if (a_pause !== 1'b0) begin fails++; $display("FAIL rmid_pause got %b want 0", a_pause); end
        tests++; if (a_inst_rdata !== 32'h0 || a_data_rdata !== 32'h0 || a_addr_err !== 1'b0) begin
            fails++; $display("FAIL rmid_outs got %h/%h/%b want 0/0/0", a_inst_rdata, a_data_rdata, a_addr_err); end
        a_mem_we = 0; rst = 0;
        exp_ird = 0; exp_drd = 0;
        xact(0, 0, 1, 0, 32'h20, 0, 0, 0, 0, 0, st);
        tests++; if (a_data_rdata !== 32'h88888888) begin
            fails++; $display("FAIL rmid_old got %h want 88888888", a_data_rdata); end
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 15)) * 4;
        if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 1) a = a + 32'($urandom_range(1, 3));
            else a = a | (32'd1 << $urandom_range(AW + 2, 31));
        end
        return a;
    endfunction

    task automatic test_random();
        int st, r;
        logic [31:0] da, ia, wd;
        for (int w = 0; w < 16; w++) xact(0, 1, 0, 0, 32'(w * 4), 0, $urandom, 0, 0, 0, st);
        for (int i = 0; i < 60; i++) begin
            r  = int'($urandom_range(1, 7));
            da = rnd_addr(); ia = rnd_addr(); wd = $urandom;
            xact(0, r[2], r[1], r[0], da, ia, wd, 0, 0, 0, st);
            tests++; if (st !== WA + 1) begin fails++; $display("FAIL rnd_stall[%0d] got %0d want %0d", i, st, WA + 1); end
            tests++; if (a_inst_rdata !== exp_ird) begin
                fails++; $display("FAIL rnd_inst[%0d] got %h want %h", i, a_inst_rdata, exp_ird); end
            tests++; if (a_data_rdata !== exp_drd) begin
                fails++; $display("FAIL rnd_data[%0d] got %h want %h", i, a_data_rdata, exp_drd); end
            tests++; if (a_addr_err !== exp_err) begin
                fails++; $display("FAIL rnd_err[%0d] got %b want %b", i, a_addr_err, exp_err); end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_back_to_back();
        test_priority();
        test_errors();
        test_wait0();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
